// File: rtl/memory_pkg.sv
// memory_pkg: shared types for the operand memory sequencer.
//   mem_state_t : sequencer FSM states
//   op_id_t     : which operand register a returning read belongs to
//   rd_tag_t    : one in-flight read, {valid, operand id, block index}
//   addr_w()    : BRAM word-address width needed to reach the last Y block
package memory_pkg;

    // Widest block index a tag can carry; operands up to 256 blocks.
    localparam int BLK_W = 8;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_N     = 4'd1,
        LOAD_NP0   = 4'd2,
        LOAD_X     = 4'd3,
        LOAD_Y     = 4'd4,
        DRAIN      = 4'd5,
        LOAD_DONE  = 4'd6,
        STORE_RES  = 4'd7,
        STORE_DONE = 4'd8
    } mem_state_t;

    typedef enum logic [1:0] {
        OP_N   = 2'd0,
        OP_NP0 = 2'd1,
        OP_X   = 2'd2,
        OP_Y   = 2'd3
    } op_id_t;

    typedef struct packed {
        logic             valid;
        op_id_t           op;
        logic [BLK_W-1:0] blk;
    } rd_tag_t;

    // Layout is n[0..S-1], n_prime_0, X[0..S-1], Y[0..S-1] from base_addr.
    function automatic int addr_w(input int s, input int base_addr);
        return $clog2(base_addr + 3 * s + 1);
    endfunction

endpackage

// File: rtl/memory_sequencer_if.sv
// memory_sequencer_if: control, BRAM and operand-register strobes of the
// operand memory sequencer.
//   master : the sequencer (drives BRAM/strobes/status, takes start)
//   slave  : top_control + BRAM/register-file side
// Parameters: AW = BRAM word-address width, IDX_W = block index width.
interface memory_sequencer_if #(
    parameter int AW    = 6,
    parameter int IDX_W = 4
);
    logic             start_i;
    logic             load_store_i;
    logic             busy_o;
    logic             BRAM_en_o;
    logic             BRAM_we_o;
    logic [AW-1:0]    BRAM_addr_o;
    logic             n_reg_write_o;
    logic             n_prime_0_reg_en_o;
    logic             X_reg_write_o;
    logic             Y_reg_write_o;
    logic             res_reg_read_o;
    logic [IDX_W-1:0] blk_idx_o;
    logic             load_done_o;
    logic             store_done_o;
    logic [15:0]      cycle_count_o;

    modport master (
        input  start_i, load_store_i,
        output busy_o, BRAM_en_o, BRAM_we_o, BRAM_addr_o,
               n_reg_write_o, n_prime_0_reg_en_o, X_reg_write_o, Y_reg_write_o,
               res_reg_read_o, blk_idx_o, load_done_o, store_done_o, cycle_count_o
    );

    modport slave (
        output start_i, load_store_i,
        input  busy_o, BRAM_en_o, BRAM_we_o, BRAM_addr_o,
               n_reg_write_o, n_prime_0_reg_en_o, X_reg_write_o, Y_reg_write_o,
               res_reg_read_o, blk_idx_o, load_done_o, store_done_o, cycle_count_o
    );
endinterface

// File: rtl/memory_sequencer_rd_tag_pipe.sv
// rd_tag_pipe: STAGES-deep shift register of read tags, matching the BRAM
// read latency so the tail tag lines up with the returning data.
//   clock_i, reset_ni : clock, asynchronous active-low clear
//   push_i            : tag for the read issued this cycle (valid=0 if none)
//   tail_o            : tag whose data is on the BRAM output now ('0 if none)
//   empty_o           : nothing queued behind the tail, including push_i, so
//                       the pipe is empty once the current tail retires
module rd_tag_pipe
    import memory_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic    clock_i,
    input  logic    reset_ni,
    input  rd_tag_t push_i,
    output rd_tag_t tail_o,
    output logic    empty_o
);

    rd_tag_t         stage_q [1:STAGES];
    logic [STAGES:0] vld_pipe;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 1; i <= STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[1] <= push_i;
            for (int i = 2; i <= STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    always_comb begin
        vld_pipe[0] = push_i.valid;
        for (int i = 1; i <= STAGES; i++) vld_pipe[i] = stage_q[i].valid;
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (vld_pipe[i]) empty_o = 1'b0;
        end
    end

    assign tail_o = vld_pipe[STAGES] ? stage_q[STAGES] : '0;

endmodule

// File: rtl/memory_sequencer.sv
// memory_sequencer: sequences BRAM reads of n, n_prime_0, X, Y into the
// operand registers and BRAM writes of the result over n.
//   clock_i  : clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : memory_sequencer_if.master (start/load_store in; BRAM
//              en/we/addr, operand strobes + blk_idx, busy, done pulses,
//              cycle_count out)
// Parameters: S blocks per operand (>=2), RD_LAT BRAM read latency (1..4),
//             BASE_ADDR word address of n block 0.
// Build option: MEM_PERF_CNT_EN adds the busy-cycle counter on
//               cycle_count_o; without it cycle_count_o is 0.
module memory_sequencer
    import memory_pkg::*;
#(
    parameter int S         = 16,
    parameter int RD_LAT    = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    memory_sequencer_if.master bus
);

    localparam int AW    = addr_w(S, BASE_ADDR);
    localparam int IDX_W = $clog2(S);
    localparam int CW    = $clog2(3 * S + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          busy, issue, wr, ld_done, st_done;
    rd_tag_t       push, tail;
    logic          pipe_empty;

    // ---------------- state register and address counter ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!busy)      cnt_q <= '0;
            else if (issue) cnt_q <= cnt_q + 1'b1;
        end
    end

    // ---------------- next state / issue decode ----------------
    // One address per cycle across all four load phases; the counter runs
    // straight through so the read stream has no bubbles.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        issue   = 1'b0;
        wr      = 1'b0;
        ld_done = 1'b0;
        st_done = 1'b0;
        push    = '0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = bus.load_store_i ? STORE_RES : LOAD_N;
            end
            LOAD_N: begin
                busy  = 1'b1;
                issue = 1'b1;
                push  = '{valid: 1'b1, op: OP_N, blk: BLK_W'(cnt_q)};
                if (cnt_q == CW'(S - 1)) state_d = LOAD_NP0;
            end
            LOAD_NP0: begin
                busy    = 1'b1;
                issue   = 1'b1;
                push    = '{valid: 1'b1, op: OP_NP0, blk: '0};
                state_d = LOAD_X;
            end
            LOAD_X: begin
                busy  = 1'b1;
                issue = 1'b1;
                push  = '{valid: 1'b1, op: OP_X, blk: BLK_W'(cnt_q - CW'(S + 1))};
                if (cnt_q == CW'(2 * S)) state_d = LOAD_Y;
            end
            LOAD_Y: begin
                busy  = 1'b1;
                issue = 1'b1;
                push  = '{valid: 1'b1, op: OP_Y, blk: BLK_W'(cnt_q - CW'(2 * S + 1))};
                if (cnt_q == CW'(3 * S)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave while the last Y strobe is at the tail so the done
                // pulse lands on the very next cycle.
                if (pipe_empty) state_d = LOAD_DONE;
            end
            LOAD_DONE: begin
                busy    = 1'b1;
                ld_done = 1'b1;
                state_d = IDLE;
            end
            STORE_RES: begin
                busy  = 1'b1;
                issue = 1'b1;
                wr    = 1'b1;
                if (cnt_q == CW'(S - 1)) state_d = STORE_DONE;
            end
            STORE_DONE: begin
                busy    = 1'b1;
                st_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- read tag pipeline ----------------
    rd_tag_pipe #(.STAGES(RD_LAT)) u_tag_pipe (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .tail_o   (tail),
        .empty_o  (pipe_empty)
    );

    // ---------------- outputs ----------------
    assign bus.busy_o             = busy;
    assign bus.BRAM_en_o          = issue;
    assign bus.BRAM_we_o          = wr;
    assign bus.BRAM_addr_o        = issue ? AW'(BASE_ADDR) + AW'(cnt_q) : '0;
    assign bus.res_reg_read_o     = wr;
    // Strobes come only from the pipe tail; tail is '0 when nothing returns,
    // and n_prime_0 tags carry block 0, so blk_idx_o idles at 0.
    assign bus.n_reg_write_o      = tail.valid && (tail.op == OP_N);
    assign bus.n_prime_0_reg_en_o = tail.valid && (tail.op == OP_NP0);
    assign bus.X_reg_write_o      = tail.valid && (tail.op == OP_X);
    assign bus.Y_reg_write_o      = tail.valid && (tail.op == OP_Y);
    assign bus.blk_idx_o          = wr ? IDX_W'(cnt_q) : IDX_W'(tail.blk);
    assign bus.load_done_o        = ld_done;
    assign bus.store_done_o       = st_done;

`ifdef MEM_PERF_CNT_EN
    logic [15:0] perf_q;
    logic        accept;

    assign accept = (state_q == IDLE) && bus.start_i;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)                       perf_q <= '0;
        else if (accept)                     perf_q <= '0;
        else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
    end

    assign bus.cycle_count_o = perf_q;
`else
    assign bus.cycle_count_o = '0;
`endif

endmodule

// File: doc/memory_sequencer.md
Name: memory_sequencer

Overview:
Parametrised successor of the FIOS operand memory FSM. It sequences BRAM reads of n, n_prime_0, X and Y into the operand registers, and BRAM writes of the result from the result register. BRAM read latency, operand block count and BRAM base address are configurable. Register write strobes are delay-aligned to returning read data, and each strobe carries a block index. Sits between top_control and the BRAM/operand register file.

Parameters:
S, 16, 17-bit blocks per multi-block operand (n, X, Y, result); S >= 2
RD_LAT, 1, BRAM read latency in cycles (1..4)
BASE_ADDR, 0, BRAM word address of block 0 of n
AW, $clog2(BASE_ADDR+3*S+1), BRAM address width (derived, localparam)

Ports:
clock_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
start_i  in  1  request; sampled only in IDLE
load_store_i  in  1  0 = load operands, 1 = store result; sampled with start_i
busy_o  out  1  high from the cycle after start is accepted through the done pulse
BRAM_en_o  out  1  BRAM enable
BRAM_we_o  out  1  BRAM write enable
BRAM_addr_o  out  AW  BRAM word address
n_reg_write_o  out  1  write n block blk_idx_o (data-aligned)
n_prime_0_reg_en_o  out  1  write n_prime_0 (data-aligned)
X_reg_write_o  out  1  write X block blk_idx_o (data-aligned)
Y_reg_write_o  out  1  write Y block blk_idx_o (data-aligned)
res_reg_read_o  out  1  result register read; same cycle as BRAM_we_o
blk_idx_o  out  $clog2(S)  block index for the active strobe
load_done_o  out  1  one-cycle pulse
store_done_o  out  1  one-cycle pulse
cycle_count_o  out  16  operation cycle count (optional feature)

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE immediately. Every output is 0. The issue pipeline is cleared. A mid-operation reset drops all in-flight strobes, and no done pulse is produced.
- States: IDLE, LOAD_N, LOAD_NP0, LOAD_X, LOAD_Y, DRAIN, LOAD_DONE, STORE_RES, STORE_DONE.
- IDLE, start_i=1: go to LOAD_N if load_store_i=0, or STORE_RES if load_store_i=1. Otherwise stay in IDLE. start_i outside IDLE is ignored.
- Address counter cnt: cleared in IDLE. Increments once per issue cycle.
- Issue cycles: BRAM_en_o=1 and BRAM_addr_o=BASE_ADDR+cnt.
  - LOAD_N: cnt 0..S-1
  - LOAD_NP0: cnt S
  - LOAD_X: cnt S+1..2S
  - LOAD_Y: cnt 2S+1..3S
  - This gives 3S+1 consecutive read cycles with no bubbles.
- Load tag pipeline:
  - Each read cycle pushes a tag {valid, operand id, block idx} into an RD_LAT-deep shift register.
  - The strobe for that operand and blk_idx_o are driven from the tail of the pipeline, exactly RD_LAT cycles after the address.
  - blk_idx_o is 0 for n_prime_0 and whenever no strobe is active.
- After the last Y address, go to DRAIN. In DRAIN, BRAM_en_o=0 and the state waits for the pipeline to empty.
- LOAD_DONE is entered the cycle after the last Y strobe. load_done_o=1 for that one cycle, then the state returns to IDLE.
- Load latency: the start-accept edge is t. Addresses are issued at t+1..t+3S+1. load_done_o is high at t+3S+2+RD_LAT.
- STORE_RES: BRAM_en_o=1, BRAM_we_o=1 and res_reg_read_o=1 for cnt 0..S-1. blk_idx_o=cnt. The result overwrites n at BASE_ADDR..BASE_ADDR+S-1.
- STORE_DONE: store_done_o=1 for one cycle at t+S+1, then the state returns to IDLE.
- Strobe exclusivity: at most one of the four operand strobes and res_reg_read_o is high in any cycle.
- BRAM_we_o is never high during a load.
- Illegal or unreached state encodings go to IDLE with all outputs 0.

Optional Feature:
MEM_PERF_CNT_EN
- Defined:
  - cycle_count_o is cleared on start accept.
  - It increments every busy cycle and saturates at 16'hFFFF.
  - It is held after the done pulse until the next accept.
  - Expected values: load 3S+2+RD_LAT; store S+1.
- Undefined: the counter is not built and cycle_count_o is tied to 0.

Decomposition:
- Package memory_pkg holds:
  - the state enum typedef mem_state_t;
  - operand id enum typedef op_id_t (OP_N, OP_NP0, OP_X, OP_Y);
  - the tag struct typedef rd_tag_t;
  - function addr_w(S, BASE_ADDR).
- One sub-module, rd_tag_pipe: a parametrised RD_LAT-stage shift register of rd_tag_t with asynchronous active-low clear and an empty flag.

Test Plan:
- S=4, RD_LAT=2, BASE_ADDR=0, load start at edge t:
  - BRAM_addr_o 0..12 at t+1..t+13;
  - n strobes idx 0..3 at t+3..t+6;
  - n_prime_0 at t+7;
  - X strobes at t+8..t+11;
  - Y strobes at t+12..t+15;
  - load_done_o at t+16 only.
- Store, S=4, BASE_ADDR=8: addresses 8..11 with we/res_reg_read at t+1..t+4, blk_idx_o 0..3, store_done_o at t+5, BRAM_we_o=0 thereafter.
- start_i held high throughout a load: exactly one operation runs, and a second load begins only after IDLE is revisited (accept at t+17).
- reset_ni pulsed low at t+6 of a load: all outputs 0 asynchronously, no load_done_o, next start behaves as a clean load.
- RD_LAT=1 and RD_LAT=4, S=2: strobes are offset RD_LAT from addresses; load_done_o at t+3S+2+RD_LAT (t+9 and t+12).
- MEM_PERF_CNT_EN, S=4, RD_LAT=2: cycle_count_o=16 after load and 5 after store. Without the macro it reads 0.
